// File: rtl/cpu_pkg.sv
// Shared ALU control codes, MIPS opcode/funct fields, ALU error codes and
// issue-controller state encoding.
package cpu_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned CTRL_W = 5;
    localparam int unsigned REG_W  = 5;

    localparam logic [CTRL_W-1:0] CTRL_ADDI    = 5'd0;
    localparam logic [CTRL_W-1:0] CTRL_ADDIU   = 5'd1;
    localparam logic [CTRL_W-1:0] CTRL_ADD     = 5'd2;
    localparam logic [CTRL_W-1:0] CTRL_SUB     = 5'd3;
    localparam logic [CTRL_W-1:0] CTRL_AND     = 5'd4;
    localparam logic [CTRL_W-1:0] CTRL_OR      = 5'd5;
    localparam logic [CTRL_W-1:0] CTRL_SLT     = 5'd6;
    localparam logic [CTRL_W-1:0] CTRL_SRL     = 5'd7;
    localparam logic [CTRL_W-1:0] CTRL_SLL     = 5'd8;
    localparam logic [CTRL_W-1:0] CTRL_LUI     = 5'd9;
    localparam logic [CTRL_W-1:0] CTRL_SW      = 5'd10;
    localparam logic [CTRL_W-1:0] CTRL_LW      = 5'd11;
    localparam logic [CTRL_W-1:0] CTRL_BEQ     = 5'd12;
    localparam logic [CTRL_W-1:0] CTRL_J       = 5'd13;
    localparam logic [CTRL_W-1:0] CTRL_ILLEGAL = 5'd14;
    localparam logic [CTRL_W-1:0] CTRL_HALT    = 5'd31;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_OVF  = 2'd1;
    localparam logic [1:0] ERR_ADDR = 2'd2;
    localparam logic [1:0] ERR_ILL  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_CHECK  = 3'd3,
        ST_FAULT  = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational MIPS instruction decode into ALU control code and operands.
module alu_ctrl_decode
    import cpu_pkg::*;
#(
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic [31:0] instr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic [4:0]  ctrl,
    output logic [31:0] num1,
    output logic [31:0] num2
);

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic [31:0] sext;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];
    assign shamt  = instr[10:6];
    assign imm    = instr[15:0];
    assign sext   = {{16{imm[15]}}, imm};

    // Unknown opcodes and funct codes fall through to the illegal code with zero operands.
    always_comb begin
        ctrl = CTRL_ILLEGAL;
        num1 = '0;
        num2 = '0;
        if (instr == HALT_WORD) begin
            ctrl = CTRL_HALT;
        end else begin
            case (opcode)
                OP_ADDI:  begin ctrl = CTRL_ADDI;  num1 = rs_data; num2 = sext; end
                OP_ADDIU: begin ctrl = CTRL_ADDIU; num1 = rs_data; num2 = sext; end
                OP_LUI:   begin ctrl = CTRL_LUI;   num2 = {16'b0, imm}; end
                OP_SW:    begin ctrl = CTRL_SW;    num1 = rs_data; num2 = sext; end
                OP_LW:    begin ctrl = CTRL_LW;    num1 = rs_data; num2 = sext; end
                OP_BEQ:   begin ctrl = CTRL_BEQ;   num1 = rs_data; num2 = rt_data; end
                OP_J:     begin ctrl = CTRL_J;     num2 = {6'b0, instr[25:0]}; end
                OP_RTYPE: begin
                    case (funct)
                        FN_ADD: begin ctrl = CTRL_ADD; num1 = rs_data; num2 = rt_data; end
                        FN_SUB: begin ctrl = CTRL_SUB; num1 = rs_data; num2 = rt_data; end
                        FN_AND: begin ctrl = CTRL_AND; num1 = rs_data; num2 = rt_data; end
                        FN_OR:  begin ctrl = CTRL_OR;  num1 = rs_data; num2 = rt_data; end
                        FN_SLT: begin ctrl = CTRL_SLT; num1 = rs_data; num2 = rt_data; end
                        FN_SRL: begin ctrl = CTRL_SRL; num1 = {27'b0, shamt}; num2 = rt_data; end
                        FN_SLL: begin ctrl = CTRL_SLL; num1 = {27'b0, shamt}; num2 = rt_data; end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller: accepts an instruction, drives the ALU for one cycle,
// checks the ALU status and retires, faults or halts.
module alu_issue_ctrl
    import cpu_pkg::*;
#(
    parameter logic [4:0]  IDLE_CTRL = 5'd13,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output logic [4:0]  rs_addr,
    output logic [4:0]  rt_addr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic [4:0]  alu_ctrl,
    output logic [31:0] alu_num1,
    output logic [31:0] alu_num2,
    input  logic        alu_error,
    input  logic [1:0]  alu_error_message,
    input  logic        alu_done,
    output logic        retire,
    output logic [31:0] retire_count,
    output logic        halted,
    output logic        faulted,
    output logic [1:0]  fault_code
);

    state_e      state;
    state_e      state_nxt;
    logic [31:0] instr_q;
    logic [4:0]  dec_ctrl;
    logic [31:0] dec_num1;
    logic [31:0] dec_num2;

    assign rs_addr = instr_q[25:21];
    assign rt_addr = instr_q[20:16];

    alu_ctrl_decode #(
        .HALT_WORD (HALT_WORD)
    ) u_decode (
        .instr   (instr_q),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .ctrl    (dec_ctrl),
        .num1    (dec_num1),
        .num2    (dec_num2)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (instr_valid && instr_ready) state_nxt = ST_DECODE;
            ST_DECODE: state_nxt = ST_ISSUE;
            ST_ISSUE:  state_nxt = ST_CHECK;
            ST_CHECK: begin
                if (alu_error)      state_nxt = ST_FAULT;
                else if (alu_done)  state_nxt = ST_HALT;
                else                state_nxt = ST_IDLE;
            end
            ST_FAULT:  state_nxt = ST_FAULT;
            ST_HALT:   state_nxt = ST_HALT;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Operands are registered at the end of DECODE so the ALU sees them only during ISSUE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            instr_q      <= '0;
            instr_ready  <= 1'b1;
            alu_ctrl     <= IDLE_CTRL;
            alu_num1     <= '0;
            alu_num2     <= '0;
            retire       <= 1'b0;
            retire_count <= '0;
            halted       <= 1'b0;
            faulted      <= 1'b0;
            fault_code   <= ERR_NONE;
        end else begin
            instr_ready <= (state_nxt == ST_IDLE);
            halted      <= (state_nxt == ST_HALT);
            faulted     <= (state_nxt == ST_FAULT);
            retire      <= 1'b0;

            if (state == ST_IDLE && instr_valid && instr_ready) begin
                instr_q <= instr;
            end

            if (state == ST_DECODE) begin
                alu_ctrl <= dec_ctrl;
                alu_num1 <= dec_num1;
                alu_num2 <= dec_num2;
            end else begin
                alu_ctrl <= IDLE_CTRL;
                alu_num1 <= '0;
                alu_num2 <= '0;
            end

            if (state == ST_CHECK) begin
                if (alu_error) begin
                    fault_code <= alu_error_message;
                end else if (!alu_done) begin
                    retire       <= 1'b1;
                    retire_count <= retire_count + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomized self-checking bench for alu_issue_ctrl with a register-file and ALU model.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] instr = '0;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [4:0]  alu_ctrl;
    logic [31:0] alu_num1;
    logic [31:0] alu_num2;
    logic        alu_error = 1'b0;
    logic [1:0]  alu_error_message = 2'd0;
    logic        alu_done = 1'b0;
    logic        retire;
    logic [31:0] retire_count;
    logic        halted;
    logic        faulted;
    logic [1:0]  fault_code;

    logic [31:0] regs [32];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_count = '0;

    always #5 clk = ~clk;

    assign rs_data = regs[rs_addr];
    assign rt_data = regs[rt_addr];

    alu_issue_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .instr_valid       (instr_valid),
        .instr_ready       (instr_ready),
        .instr             (instr),
        .rs_addr           (rs_addr),
        .rt_addr           (rt_addr),
        .rs_data           (rs_data),
        .rt_data           (rt_data),
        .alu_ctrl          (alu_ctrl),
        .alu_num1          (alu_num1),
        .alu_num2          (alu_num2),
        .alu_error         (alu_error),
        .alu_error_message (alu_error_message),
        .alu_done          (alu_done),
        .retire            (retire),
        .retire_count      (retire_count),
        .halted            (halted),
        .faulted           (faulted),
        .fault_code        (fault_code)
    );

    // ALU stand-in: sticky error and done flags, sampled every edge.
    function automatic logic [1:0] alu_status(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] s;
        s = a + b;
        case (c)
            5'd0, 5'd2:   return (a[31] == b[31] && s[31] != a[31]) ? 2'd1 : 2'd0;
            5'd3: begin
                s = a - b;
                return (a[31] != b[31] && s[31] != a[31]) ? 2'd1 : 2'd0;
            end
            5'd10, 5'd11: return (s[1:0] != 2'b00) ? 2'd2 : 2'd0;
            5'd14:        return 2'd3;
            default:      return 2'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            alu_error         <= 1'b0;
            alu_error_message <= 2'd0;
            alu_done          <= 1'b0;
        end else if (!alu_error) begin
            if (alu_status(alu_ctrl, alu_num1, alu_num2) != 2'd0) begin
                alu_error         <= 1'b1;
                alu_error_message <= alu_status(alu_ctrl, alu_num1, alu_num2);
            end
            if (alu_ctrl == 5'd31) alu_done <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: instruction semantics -> expected ctrl/operands and outcome
    // (0 retire, 1..3 fault code, 4 halt).
    function automatic void ref_model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                                      output logic [4:0] c, output logic [31:0] n1, output logic [31:0] n2,
                                      output int outc);
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [31:0] sx;
        longint      sum;
        op   = ins[31:26];
        fn   = ins[5:0];
        sx   = 32'($signed(ins[15:0]));
        c    = 5'd14;
        n1   = 0;
        n2   = 0;
        outc = 3;
        if (ins == 32'hFFFF_FFFF) begin
            c = 5'd31; outc = 4;
        end else if (op == 6'h08 || op == 6'h09) begin
            c = (op == 6'h08) ? 5'd0 : 5'd1; n1 = a; n2 = sx;
            sum  = longint'($signed(a)) + longint'($signed(sx));
            outc = (op == 6'h08 && (sum > 64'sd2147483647 || sum < -64'sd2147483648)) ? 1 : 0;
        end else if (op == 6'h0F) begin
            c = 5'd9; n2 = {16'h0, ins[15:0]}; outc = 0;
        end else if (op == 6'h2B || op == 6'h23) begin
            c = (op == 6'h2B) ? 5'd10 : 5'd11; n1 = a; n2 = sx;
            outc = ((a + sx) % 4 != 0) ? 2 : 0;
        end else if (op == 6'h04) begin
            c = 5'd12; n1 = a; n2 = b; outc = 0;
        end else if (op == 6'h02) begin
            c = 5'd13; n2 = {6'h0, ins[25:0]}; outc = 0;
        end else if (op == 6'h00 && (fn == 6'h02 || fn == 6'h00)) begin
            c = (fn == 6'h02) ? 5'd7 : 5'd8; n1 = 32'(ins[10:6]); n2 = b; outc = 0;
        end else if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22)) begin
            c    = (fn == 6'h20) ? 5'd2 : 5'd3; n1 = a; n2 = b;
            sum  = (fn == 6'h20) ? longint'($signed(a)) + longint'($signed(b))
                                 : longint'($signed(a)) - longint'($signed(b));
            outc = (sum > 64'sd2147483647 || sum < -64'sd2147483648) ? 1 : 0;
        end else if (op == 6'h00 && (fn == 6'h24 || fn == 6'h25 || fn == 6'h2A)) begin
            c = (fn == 6'h24) ? 5'd4 : (fn == 6'h25) ? 5'd5 : 5'd6; n1 = a; n2 = b; outc = 0;
        end
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        exp_count = '0;
        check("rst_ready", 32'(instr_ready), 32'd1);
        check("rst_count", retire_count, 32'd0);
        check("rst_ctrl", 32'(alu_ctrl), 32'd13);
    endtask

    // Runs one instruction from IDLE; assumes sampling point is #1 after an edge.
    task automatic do_instr(input logic [31:0] ins, output int outc);
        logic [4:0]  ec;
        logic [31:0] e1;
        logic [31:0] e2;
        ref_model(ins, regs[ins[25:21]], regs[ins[20:16]], ec, e1, e2, outc);
        check("ready_start", 32'(instr_ready), 32'd1);
        instr_valid = 1'b1;
        instr       = ins;
        @(posedge clk); #1;
        instr_valid = (outc != 0);
        instr       = $urandom;
        check("ready_decode", 32'(instr_ready), 32'd0);
        check("rs_addr", 32'(rs_addr), 32'(ins[25:21]));
        check("rt_addr", 32'(rt_addr), 32'(ins[20:16]));
        @(posedge clk); #1;
        check("issue_ctrl", 32'(alu_ctrl), 32'(ec));
        check("issue_num1", alu_num1, e1);
        check("issue_num2", alu_num2, e2);
        @(posedge clk); #1;
        check("check_ctrl", 32'(alu_ctrl), 32'd13);
        check("check_ready", 32'(instr_ready), 32'd0);
        @(posedge clk); #1;
        if (outc == 0) exp_count = exp_count + 32'd1;
        check("retire", 32'(retire), (outc == 0) ? 32'd1 : 32'd0);
        check("retire_count", retire_count, exp_count);
        check("ready_after", 32'(instr_ready), (outc == 0) ? 32'd1 : 32'd0);
        check("faulted", 32'(faulted), (outc >= 1 && outc <= 3) ? 32'd1 : 32'd0);
        check("halted", 32'(halted), (outc == 4) ? 32'd1 : 32'd0);
        if (outc >= 1 && outc <= 3) check("fault_code", 32'(fault_code), 32'(outc));
        @(posedge clk); #1;
        check("retire_pulse", 32'(retire), 32'd0);
        check("ready_hold", 32'(instr_ready), (outc == 0) ? 32'd1 : 32'd0);
        check("idle_ctrl", 32'(alu_ctrl), 32'd13);
        instr_valid = 1'b0;
    endtask

    function automatic logic [31:0] gen_instr();
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sh;
        logic [15:0] imm;
        int          k;
        rs  = 5'($urandom);
        rt  = 5'($urandom);
        rd  = 5'($urandom);
        sh  = 5'($urandom);
        imm = 16'($urandom);
        k   = int'($urandom_range(0, 16));
        if ($urandom_range(0, 1) == 0) imm[1:0] = 2'b00;
        case (k)
            0:  return {6'h00, rs, rt, rd, sh, 6'h20};
            1:  return {6'h00, rs, rt, rd, sh, 6'h22};
            2:  return {6'h00, rs, rt, rd, sh, 6'h24};
            3:  return {6'h00, rs, rt, rd, sh, 6'h25};
            4:  return {6'h00, rs, rt, rd, sh, 6'h2A};
            5:  return {6'h00, rs, rt, rd, sh, 6'h02};
            6:  return {6'h00, rs, rt, rd, sh, 6'h00};
            7:  return {6'h08, rs, rt, imm};
            8:  return {6'h09, rs, rt, imm};
            9:  return {6'h0F, rs, rt, imm};
            10: return {6'h2B, rs, rt, imm};
            11: return {6'h23, rs, rt, imm};
            12: return {6'h04, rs, rt, imm};
            13: return {6'h02, rs, rt, imm};
            14: return {6'h00, rs, rt, rd, sh, 6'h3F};
            15: return {6'h3F, rs, rt, imm[15:1], 1'b0};
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    initial begin
        int outc;
        for (int i = 0; i < 32; i++) regs[i] = '0;

        @(posedge clk); @(posedge clk); #1;
        check("reset_ready", 32'(instr_ready), 32'd1);
        check("reset_ctrl", 32'(alu_ctrl), 32'd13);
        check("reset_num1", alu_num1, 32'd0);
        check("reset_num2", alu_num2, 32'd0);
        check("reset_flags", {28'd0, retire, halted, faulted, 1'b0}, 32'd0);
        check("reset_count", retire_count, 32'd0);
        check("reset_fcode", 32'(fault_code), 32'd0);
        rst = 1'b1;

        regs[1] = 32'd5; regs[2] = 32'd7;
        do_instr(32'h0022_1820, outc);
        check("add_outcome", 32'(outc), 32'd0);
        regs[1] = 32'd3;
        do_instr(32'h2022_FFFF, outc);
        regs[2] = 32'h80;
        do_instr(32'h0002_1902, outc);

        regs[1] = 32'h7FFF_FFFF; regs[2] = 32'd1;
        do_instr(32'h0022_1820, outc);
        instr_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("fault_ready_held", 32'(instr_ready), 32'd0);
        check("fault_sticky", 32'(faulted), 32'd1);
        instr_valid = 1'b0;
        do_reset();

        do_instr(32'hFC00_0000, outc);
        do_reset();
        regs[1] = 32'd0;
        do_instr(32'h8C22_0001, outc);
        do_reset();
        do_instr(32'hFFFF_FFFF, outc);
        do_reset();

        // Reset while the ALU is being driven.
        regs[1] = 32'd5; regs[2] = 32'd7;
        instr_valid = 1'b1; instr = 32'h0022_1820;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        check("mid_issue_ctrl", 32'(alu_ctrl), 32'd2);
        do_reset();
        check("mid_reset_num1", alu_num1, 32'd0);
        do_instr(32'h0022_1820, outc);

        for (int n = 0; n < 120; n++) begin
            for (int r = 0; r < 32; r++)
                regs[r] = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 255)) * 32'd4;
            do_instr(gen_instr(), outc);
            if (outc != 0) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
